// File: rtl/cacheline_burst_adapter_if.sv
// Cache-line / memory-burst signal bundle for cacheline_burst_adapter.
// slave = adapter view, master = cache + memory environment view.
interface cacheline_burst_adapter_if #(
  parameter int s_line  = 256,
  parameter int s_burst = 64
);
  logic               line_read;
  logic               line_write;
  logic [31:0]        line_address;
  logic [s_line-1:0]  line_wdata;
  logic [s_line-1:0]  line_rdata;
  logic               line_resp;
  logic               mem_read;
  logic               mem_write;
  logic [31:0]        mem_address;
  logic [s_burst-1:0] mem_wdata;
  logic [s_burst-1:0] mem_rdata;
  logic               mem_resp;

  modport slave (
    input  line_read,
    input  line_write,
    input  line_address,
    input  line_wdata,
    output line_rdata,
    output line_resp,
    output mem_read,
    output mem_write,
    output mem_address,
    output mem_wdata,
    input  mem_rdata,
    input  mem_resp
  );

  modport master (
    output line_read,
    output line_write,
    output line_address,
    output line_wdata,
    input  line_rdata,
    input  line_resp,
    input  mem_read,
    input  mem_write,
    input  mem_address,
    input  mem_wdata,
    output mem_rdata,
    output mem_resp
  );
endinterface

// File: rtl/cacheline_burst_adapter.sv
// Splits cache-line reads/writes into s_line/s_burst memory beats.
// Define CACHELINE_BURST_ADAPTER_ALIGN_EN to line-align the latched address.
module cacheline_burst_adapter #(
  parameter int s_line   = 256,
  parameter int s_burst  = 64,
  parameter int s_offset = 5
) (
  input  logic clk,
  input  logic rst,
  cacheline_burst_adapter_if.slave bus
);
  localparam int BEATS = s_line / s_burst;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  if (s_offset < 1 || s_offset > 31 ||
      (s_line % s_burst) != 0) begin : g_cfg_err
    $error("cacheline_burst_adapter: bad geometry");
  end

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [31:0]   r_addr;
  logic [31:0]   w_addr_in;
  logic          w_lat_rd;
  logic          w_lat_wr;
  logic          w_beat;

  logic [BEATS-1:0][s_burst-1:0] r_wdata;
  logic [BEATS-1:0][s_burst-1:0] r_rdata;

`ifdef CACHELINE_BURST_ADAPTER_ALIGN_EN
  assign w_addr_in = {
    bus.line_address[31:s_offset],
    {s_offset{1'b0}}
  };
`else
  assign w_addr_in = bus.line_address;
`endif

  assign bus.line_rdata = r_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_lat_rd        = 1'b0;
    w_lat_wr        = 1'b0;
    w_beat          = 1'b0;
    bus.line_resp   = 1'b0;
    bus.mem_read    = 1'b0;
    bus.mem_write   = 1'b0;
    bus.mem_address = '0;
    bus.mem_wdata   = '0;
    unique case (r_state)
      IDLE: begin
        // read takes priority over a simultaneous write-back
        if (bus.line_read) begin
          w_lat_rd    = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = READ;
        end else if (bus.line_write) begin
          w_lat_wr    = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = WRITE;
        end
      end
      READ, WRITE: begin
        bus.mem_read    = (r_state == READ);
        bus.mem_write   = (r_state == WRITE);
        bus.mem_address = r_addr;
        if (r_state == WRITE) begin
          bus.mem_wdata = r_wdata[r_cnt];
        end
        if (bus.mem_resp) begin
          w_beat = 1'b1;
          if (r_cnt == LAST) begin
            w_cnt_nxt   = '0;
            w_state_nxt = DONE;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
      end
      DONE: begin
        bus.line_resp = 1'b1;
        w_state_nxt   = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      if (w_lat_rd || w_lat_wr) begin
        r_addr <= w_addr_in;
      end
      if (w_lat_wr) begin
        r_wdata <= bus.line_wdata;
      end
      if (w_beat && r_state == READ) begin
        r_rdata[r_cnt] <= bus.mem_rdata;
      end
    end
  end
endmodule

// File: tb/tb_cacheline_burst_adapter.sv
// Directed + randomized bench for cacheline_burst_adapter.
// Reference: a line is just the concatenation of its beats, LSB beat first.
module tb_cacheline_burst_adapter;
  localparam int SL = 256;
  localparam int SB = 64;
  localparam int NB = SL / SB;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cacheline_burst_adapter_if #(.s_line(SL), .s_burst(SB)) bus();

  cacheline_burst_adapter #(
    .s_line(SL),
    .s_burst(SB),
    .s_offset(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [SL-1:0] m_rdata;

  task automatic chk(input string tag,
                     input logic [SL-1:0] obs,
                     input logic [SL-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_addr(input logic [31:0] a);
`ifdef CACHELINE_BURST_ADAPTER_ALIGN_EN
    return a & 32'hFFFF_FFE0;
`else
    return a;
`endif
  endfunction

  task automatic idle_chk(input string tag);
    chk({tag, ".mem_read"}, SL'(bus.mem_read), '0);
    chk({tag, ".mem_write"}, SL'(bus.mem_write), '0);
    chk({tag, ".line_resp"}, SL'(bus.line_resp), '0);
    chk({tag, ".mem_address"}, SL'(bus.mem_address), '0);
    chk({tag, ".mem_wdata"}, SL'(bus.mem_wdata), '0);
    chk({tag, ".line_rdata"}, bus.line_rdata, m_rdata);
  endtask

  // One line transfer; abort_at >= 0 leaves it mid-burst after that many beats.
  task automatic xfer(input bit wr, input bit both,
                      input logic [31:0] a,
                      input logic [SL-1:0] d,
                      input bit use_pat,
                      input logic [31:0] pat,
                      input int exp_cyc,
                      input int abort_at);
    int k;
    int cyc;
    bit rd;
    bit r;
    k = 0;
    cyc = 0;
    rd = !wr || both;
    @(negedge clk);
    bus.line_read    = rd;
    bus.line_write   = wr || both;
    bus.line_address = a;
    bus.line_wdata   = rd ? {8{$urandom()}} : d;
    while (k < NB && cyc < 64) begin
      @(negedge clk);
      chk("req.mem_read", SL'(bus.mem_read), SL'(rd));
      chk("req.mem_write", SL'(bus.mem_write), SL'(!rd));
      chk("req.mem_address", SL'(bus.mem_address),
          SL'(exp_addr(a)));
      chk("req.line_resp", SL'(bus.line_resp), '0);
      chk("req.mem_wdata", SL'(bus.mem_wdata),
          rd ? '0 : SL'(d[k*SB +: SB]));
      if (abort_at >= 0 && k == abort_at) begin
        bus.mem_resp = 1'b0;
        return;
      end
      r = use_pat ? pat[cyc] : ($urandom_range(0, 2) != 0);
      bus.mem_resp  = r;
      bus.mem_rdata = r ? d[k*SB +: SB] : {$urandom(), $urandom()};
      if (r) k++;
      cyc++;
    end
    chk("beats_done", SL'(k), SL'(NB));
    if (exp_cyc > 0) chk("req_cycles", SL'(cyc), SL'(exp_cyc));
    @(negedge clk);
    if (rd) m_rdata = d;
    chk("done.line_resp", SL'(bus.line_resp), SL'(1));
    chk("done.mem_read", SL'(bus.mem_read), '0);
    chk("done.mem_write", SL'(bus.mem_write), '0);
    chk("done.mem_address", SL'(bus.mem_address), '0);
    chk("done.line_rdata", bus.line_rdata, m_rdata);
    bus.line_read  = 1'b0;
    bus.line_write = 1'b0;
    bus.mem_resp   = 1'b1;
    bus.mem_rdata  = {$urandom(), $urandom()};
    @(negedge clk);
    bus.mem_resp = 1'b0;
    idle_chk("post");
  endtask

  initial begin
    logic [SL-1:0] d;
    rst              = 1'b1;
    bus.line_read    = 1'b0;
    bus.line_write   = 1'b0;
    bus.line_address = '0;
    bus.line_wdata   = '0;
    bus.mem_rdata    = '0;
    bus.mem_resp     = 1'b0;
    m_rdata          = '0;
    repeat (3) @(negedge clk);
    idle_chk("reset");
    rst = 1'b0;

    d = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
    xfer(1'b0, 1'b0, 32'h0000_1240, d, 1'b1, '1, 4, -1);

    d = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
    xfer(1'b1, 1'b0, 32'h0000_2000, d, 1'b1, '1, 4, -1);

    d = {8{$urandom()}};
    xfer(1'b0, 1'b0, 32'h0000_3000, d, 1'b1, 32'b1011001, 7, -1);

    d = {8{$urandom()}};
    xfer(1'b0, 1'b1, 32'h0000_4000, d, 1'b1, '1, 4, -1);

    d = {8{$urandom()}};
    xfer(1'b0, 1'b0, 32'h0000_125F, d, 1'b1, '1, 4, -1);

    repeat (2) begin
      @(negedge clk);
      bus.mem_resp  = 1'b1;
      bus.mem_rdata = {$urandom(), $urandom()};
    end
    @(negedge clk);
    bus.mem_resp = 1'b0;
    idle_chk("idle_resp");

    d = {8{$urandom()}};
    xfer(1'b0, 1'b0, 32'h0000_5000, d, 1'b1, '1, -1, 2);
    rst           = 1'b1;
    bus.line_read = 1'b0;
    @(negedge clk);
    rst     = 1'b0;
    m_rdata = '0;
    idle_chk("abort");
    repeat (3) begin
      @(negedge clk);
      idle_chk("abort_quiet");
    end
    d = {8{$urandom()}};
    xfer(1'b0, 1'b0, 32'h0000_6000, d, 1'b1, '1, 4, -1);

    for (int i = 0; i < 30; i++) begin
      d = {8{$urandom()}};
      xfer(bit'($urandom_range(0, 1)), 1'b0, $urandom(), d,
           1'b0, '0, -1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/cacheline_burst_adapter.md
CACHELINE_BURST_ADAPTER -- requirements
Module: cacheline_burst_adapter

Interface
REQ-001 Parameter s_line, default 256, cacheline width in bits.
REQ-002 Parameter s_burst, default 64, memory beat width in bits; beats = s_line/s_burst (default 4).
REQ-003 Parameter s_offset, default 5, line offset bits of the address.
REQ-004 clk  input  1  sole clock, rising-edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 line_read  input  1  line read request from cache downstream port, held until line_resp.
REQ-007 line_write  input  1  line write-back request, held until line_resp.
REQ-008 line_address  input  32  line address.
REQ-009 line_wdata  input  s_line  line to write back.
REQ-010 line_rdata  output  s_line  assembled line.
REQ-011 line_resp  output  1  single-cycle completion pulse.
REQ-012 mem_read  output  1  burst read request to physical memory.
REQ-013 mem_write  output  1  burst write request to physical memory.
REQ-014 mem_address  output  32  burst address.
REQ-015 mem_wdata  output  s_burst  current write beat.
REQ-016 mem_rdata  input  s_burst  current read beat.
REQ-017 mem_resp  input  1  per-beat acknowledge; qualifies mem_rdata or consumes mem_wdata.

Function
REQ-018 The states SHALL be IDLE, READ, WRITE and DONE.
REQ-019 IDLE: line_read=1 SHALL latch line_address and go to READ; else line_write=1 SHALL latch line_address and line_wdata and go to WRITE. Read wins when both are high.
REQ-020 mem_read SHALL be 1 exactly in READ; mem_write SHALL be 1 exactly in WRITE (both decoded from state, no combinational path from line_*).
REQ-021 mem_address SHALL equal the latched address in READ and WRITE, and 0 otherwise.
REQ-022 A beat counter of log2(beats) bits SHALL be 0 on entry to READ/WRITE and increment on each mem_resp in those states.
REQ-023 READ: each mem_resp SHALL store mem_rdata into line_rdata[count*s_burst +: s_burst].
REQ-024 WRITE: mem_wdata SHALL equal latched line_wdata[count*s_burst +: s_burst]; 0 outside WRITE.
REQ-025 The mem_resp for beat beats-1 SHALL move READ/WRITE to DONE and wrap the counter to 0.
REQ-026 DONE SHALL assert line_resp for exactly one cycle, then go to IDLE unconditionally; line_read/line_write are not sampled in DONE.
REQ-027 line_rdata SHALL hold its value from the last read until the next read beat or reset; a write SHALL not modify it.
REQ-028 mem_resp in IDLE or DONE SHALL be ignored.
REQ-029 Gaps (mem_resp=0) between beats SHALL be tolerated with no timeout; the request stays asserted.
REQ-030 Latency: request sampled in cycle 0, memory request in cycle 1, beats at cycles 1..4 with mem_resp continuously high, line_resp in cycle 5.

Reset
REQ-031 rst=1 at any clock edge, including mid-burst, SHALL force IDLE, counter 0, latched address 0, latched wdata 0, line_rdata 0.
REQ-032 During and after reset, line_resp, mem_read and mem_write SHALL be 0 and mem_address and mem_wdata SHALL be 0 until a new request.
REQ-033 An aborted burst SHALL produce no line_resp.

Configuration
REQ-034 With CACHELINE_BURST_ADAPTER_ALIGN_EN defined, the latched address bits [s_offset-1:0] SHALL be forced to 0 so that mem_address is always line-aligned.
REQ-035 Without CACHELINE_BURST_ADAPTER_ALIGN_EN, the latched address SHALL be line_address unmodified.

Verification
REQ-036 Read: line_read at 0x0000_1240, beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on consecutive mem_resp -> line_rdata = {0x44..,0x33..,0x22..,0x11..} and line_resp is 1 in cycle 5 only.
REQ-037 Write: line_wdata = {0xDDDD..,0xCCCC..,0xBBBB..,0xAAAA..} -> mem_wdata AAAA,BBBB,CCCC,DDDD in order, mem_write drops after the 4th mem_resp, and there is one line_resp.
REQ-038 Stalled read: mem_resp pattern 1,0,0,1,1,0,1 -> mem_read is held for 7 cycles, beats land in slots 0..3, and line_resp follows the last beat by one cycle.
REQ-039 Simultaneous line_read=line_write=1 -> mem_read is asserted, mem_write stays 0, and line_wdata is not latched.
REQ-040 rst after beat 2 of a read -> the next cycle shows IDLE with all outputs 0 and no line_resp; a following read completes normally.
REQ-041 With the macro defined, line_address 0x0000_125F -> mem_address 0x0000_1240; without the macro -> mem_address 0x0000_125F.
